fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end for the 16-bit processor. It owns the program counter and runs a request/done handshake with instruction memory. It presents one 16-bit instruction word at a time to the control decoder. It takes PC redirects from the branch/jump resolution logic and stops permanently after a HALT instruction (opcode 5'b00000) has been consumed.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  16  fetch address; held stable while a request is outstanding.
- imem_rdata  in  16  instruction word; sampled only when imem_done=1.
- imem_done  in  1  memory completion; may be asserted in the same cycle as imem_req, or any later cycle.
- redirect  in  1  single-cycle pulse: replace the PC with redirect_pc.
- redirect_pc  in  16  redirect target; bit 0 is ignored and forced to 0.
- stall  in  1  downstream hold; the presented instruction is not consumed while this is 1.
- instruction  out  16  instruction word presented to the decoder.
- pc_plus2  out  16  address of the presented instruction + 2, used as the link/branch base.
- inst_valid  out  1  instruction and pc_plus2 are valid.
- halted  out  1  the fetch unit has stopped.

## Operation
- Registers:
  - pc: next fetch address.
  - fetch_addr: address of the outstanding request.
  - ir: instruction register.
  - pcp2: address of the presented instruction + 2.
  - squash: the outstanding fetch is to be discarded.
  - state.
- State START:
  - imem_req=0.
  - Next cycle: fetch_addr<=pc, go to FETCH.
- State FETCH:
  - imem_req=1, imem_addr=fetch_addr.
  - imem_done=1 and squash=0 and no redirect: ir<=imem_rdata, pcp2<=fetch_addr+2, pc<=fetch_addr+2, go to ISSUE.
  - imem_done=1 and (squash=1 or redirect=1): discard the data, squash<=0, fetch_addr<=next pc, stay in FETCH. The next cycle is a new request.
  - redirect=1 with imem_done=0: pc<=redirect_pc & 16'hFFFE, squash<=1. imem_addr is unchanged until done.
- State ISSUE:
  - inst_valid=1, instruction=ir, pc_plus2=pcp2.
  - redirect=1: takes priority over consumption. pc<=redirect_pc & 16'hFFFE, ir is dropped, fetch_addr<=the new pc, go to FETCH.
  - stall=1: hold all outputs.
  - stall=0 and ir[15:11]=5'b00000: go to HALTED.
  - stall=0 otherwise: fetch_addr<=pc, go to FETCH.
- State HALTED:
  - imem_req=0, inst_valid=0, halted=1.
  - redirect, stall and imem_done are ignored. Only rst leaves this state.
- Arithmetic: all PC arithmetic is 16-bit modulo; 16'hFFFE+2 = 16'h0000.
- pc_plus2 when a redirect lands in FETCH: the redirect still applies when it coincides with done; pc takes redirect_pc, never fetch_addr+2.

## Timing
- Reset values (asynchronous):
  - state=START, pc=RESET_PC, fetch_addr=RESET_PC, squash=0.
  - ir=16'h0800 (NOP), pcp2=16'h0000.
  - imem_req=0, inst_valid=0, halted=0.
  - imem_addr=RESET_PC, instruction=16'h0800, pc_plus2=16'h0000.
- First request: imem_req rises in the first cycle after rst deasserts.
- Minimum latency, with a zero-wait memory (done in the same cycle as req): FETCH→ISSUE takes 1 cycle. inst_valid rises the cycle after the request cycle.
- Steady-state throughput, no stall, zero-wait memory: one instruction per 2 cycles (FETCH/ISSUE alternate).
- Each memory wait cycle adds one FETCH cycle. imem_addr is constant across them.
- Redirect effect: the redirect is registered. The first request to the target is issued the cycle after the redirect cycle, or after the squashed fetch completes.
- Reset asserted mid-operation: outputs return to their reset values immediately. An in-flight memory response is ignored, because done is never sampled in START.

## Test plan
- Reset and straight line:
  - Stimulus: RESET_PC=0, zero-wait memory holding ADDI words at 0x0000, 0x0002, 0x0004.
  - Required: requests go to 0,2,4 on alternating cycles; pc_plus2=2,4,6 while the matching word is valid.
- Wait states and stall:
  - Stimulus: done delayed 3 cycles; stall held high 2 cycles in ISSUE.
  - Required: imem_addr stable over the 3 wait cycles; instruction/inst_valid held for the 2 stall cycles; no extra request issued.
- Redirect in ISSUE:
  - Stimulus: redirect_pc=16'h0041 with stall=1, while the word at 0x0010 is presented.
  - Required: that word is never consumed; next imem_addr=16'h0040; pc_plus2=16'h0042.
- Redirect during an outstanding fetch:
  - Stimulus: redirect to 0x0100 at wait cycle 1; done arrives at cycle 3 with 16'hDEAD.
  - Required: 16'hDEAD is never valid; next request goes to 0x0100.
- HALT:
  - Stimulus: word 16'h0000 at 0x0006.
  - Required: after it is consumed, halted=1, imem_req=0, inst_valid=0. A later redirect has no effect. rst restarts fetching at RESET_PC.
- Wrap:
  - Stimulus: RESET_PC=16'hFFFE.
  - Required: pc_plus2=16'h0000; second request to 16'h0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, runs the request/done handshake
// with instruction memory and presents one instruction at a time.
//
// state  | meaning
// -------+-----------------------------------------------------------
// START  | one idle cycle after reset; latch pc into fetch_addr
// FETCH  | request outstanding at fetch_addr, waiting for imem_done
// ISSUE  | ir/pcp2 presented to the decoder until consumed or redirected
// HALTED | HALT consumed; only rst leaves
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    output logic [15:0] instruction,
    output logic [15:0] pc_plus2,
    output logic        inst_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        START  = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [15:0] NOP_WORD = 16'h0800;

    state_t      state, state_n;
    logic [15:0] pc, pc_n;
    logic [15:0] fetch_addr, fetch_addr_n;
    logic [15:0] ir, ir_n;
    logic [15:0] pcp2, pcp2_n;
    logic        squash, squash_n;

    logic [15:0] target;
    logic [15:0] fetch_next;

    assign target     = {redirect_pc[15:1], 1'b0};
    assign fetch_next = fetch_addr + 16'd2;

    // State and datapath registers; reset lands on the NOP/RESET_PC values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= START;
            pc         <= RESET_PC;
            fetch_addr <= RESET_PC;
            ir         <= NOP_WORD;
            pcp2       <= 16'h0000;
            squash     <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            fetch_addr <= fetch_addr_n;
            ir         <= ir_n;
            pcp2       <= pcp2_n;
            squash     <= squash_n;
        end
    end

    // Next-state and datapath update; everything holds unless a case changes it.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        fetch_addr_n = fetch_addr;
        ir_n         = ir;
        pcp2_n       = pcp2;
        squash_n     = squash;
        case (state)
            START: begin
                fetch_addr_n = pc;
                state_n      = FETCH;
            end
            FETCH: begin
                if (imem_done) begin
                    if (squash || redirect) begin
                        // Stale data is dropped; the new request starts next cycle.
                        squash_n = 1'b0;
                        if (redirect) begin
                            pc_n         = target;
                            fetch_addr_n = target;
                        end else begin
                            fetch_addr_n = pc;
                        end
                    end else begin
                        ir_n    = imem_rdata;
                        pcp2_n  = fetch_next;
                        pc_n    = fetch_next;
                        state_n = ISSUE;
                    end
                end else if (redirect) begin
                    // Address must stay put until memory completes, so only remember.
                    pc_n     = target;
                    squash_n = 1'b1;
                end
            end
            ISSUE: begin
                if (redirect) begin
                    pc_n         = target;
                    fetch_addr_n = target;
                    state_n      = FETCH;
                end else if (!stall) begin
                    if (ir[15:11] == 5'b00000) begin
                        state_n = HALTED;
                    end else begin
                        fetch_addr_n = pc;
                        state_n      = FETCH;
                    end
                end
            end
            HALTED: begin
                state_n = HALTED;
            end
            default: begin
                state_n = START;
            end
        endcase
    end

    assign imem_req    = (state == FETCH);
    assign imem_addr   = fetch_addr;
    assign inst_valid  = (state == ISSUE);
    assign halted      = (state == HALTED);
    assign instruction = ir;
    assign pc_plus2    = pcp2;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table plus hand-written
// reset and PC-wrap sequences.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_done;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall;
    logic [15:0] instruction;
    logic [15:0] pc_plus2;
    logic        inst_valid;
    logic        halted;

    logic        rst_w;
    logic        imem_req_w;
    logic [15:0] imem_addr_w;
    logic [15:0] instruction_w;
    logic [15:0] pc_plus2_w;
    logic        inst_valid_w;
    logic        halted_w;

    int checks;
    int passed;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_done   (imem_done),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .instruction (instruction),
        .pc_plus2    (pc_plus2),
        .inst_valid  (inst_valid),
        .halted      (halted)
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clk         (clk),
        .rst         (rst_w),
        .imem_req    (imem_req_w),
        .imem_addr   (imem_addr_w),
        .imem_rdata  (16'h2001),
        .imem_done   (1'b1),
        .redirect    (1'b0),
        .redirect_pc (16'h0000),
        .stall       (1'b0),
        .instruction (instruction_w),
        .pc_plus2    (pc_plus2_w),
        .inst_valid  (inst_valid_w),
        .halted      (halted_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        done;
        logic [15:0] rdata;
        logic        redir;
        logic [15:0] rpc;
        logic        stl;
        logic        req;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] instr;
        logic [15:0] pcp2;
        logic        halt;
    } vec_t;

    localparam int NVEC = 29;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic d, logic [15:0] rd, logic rr, logic [15:0] rp, logic s,
                                logic q, logic [15:0] a, logic v, logic [15:0] i,
                                logic [15:0] p, logic h);
        vec_t r;
        r.done = d; r.rdata = rd; r.redir = rr; r.rpc = rp; r.stl = s;
        r.req = q; r.addr = a; r.valid = v; r.instr = i; r.pcp2 = p; r.halt = h;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        else
            passed++;
    endtask

    task automatic chk_all(input string tag, input logic q, input logic [15:0] a, input logic v,
                           input logic [15:0] i, input logic [15:0] p, input logic h);
        chk({tag, " imem_req"},    {15'd0, imem_req},   {15'd0, q});
        chk({tag, " imem_addr"},   imem_addr,           a);
        chk({tag, " inst_valid"},  {15'd0, inst_valid}, {15'd0, v});
        chk({tag, " instruction"}, instruction,         i);
        chk({tag, " pc_plus2"},    pc_plus2,            p);
        chk({tag, " halted"},      {15'd0, halted},     {15'd0, h});
    endtask

    initial begin
        checks = 0;
        passed = 0;

        //            done rdata    rr rpc      st | req addr    val instr    pcp2     hlt
        vecs[0]  = mk(0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0000, 0, 16'h0800, 16'h0000, 0);
        vecs[1]  = mk(1, 16'h2001, 0, 16'h0000, 0,  1, 16'h0000, 0, 16'h0800, 16'h0000, 0);
        vecs[2]  = mk(0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0000, 1, 16'h2001, 16'h0002, 0);
        vecs[3]  = mk(1, 16'h2002, 0, 16'h0000, 0,  1, 16'h0002, 0, 16'h2001, 16'h0002, 0);
        vecs[4]  = mk(0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0002, 1, 16'h2002, 16'h0004, 0);
        vecs[5]  = mk(0, 16'h0000, 0, 16'h0000, 0,  1, 16'h0004, 0, 16'h2002, 16'h0004, 0);
        vecs[6]  = mk(0, 16'h0000, 0, 16'h0000, 0,  1, 16'h0004, 0, 16'h2002, 16'h0004, 0);
        vecs[7]  = mk(0, 16'h0000, 0, 16'h0000, 0,  1, 16'h0004, 0, 16'h2002, 16'h0004, 0);
        vecs[8]  = mk(1, 16'h2003, 0, 16'h0000, 0,  1, 16'h0004, 0, 16'h2002, 16'h0004, 0);
        vecs[9]  = mk(0, 16'h0000, 0, 16'h0000, 1,  0, 16'h0004, 1, 16'h2003, 16'h0006, 0);
        vecs[10] = mk(0, 16'h0000, 0, 16'h0000, 1,  0, 16'h0004, 1, 16'h2003, 16'h0006, 0);
        vecs[11] = mk(0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0004, 1, 16'h2003, 16'h0006, 0);
        vecs[12] = mk(0, 16'h0000, 1, 16'h0100, 0,  1, 16'h0006, 0, 16'h2003, 16'h0006, 0);
        vecs[13] = mk(0, 16'h0000, 0, 16'h0000, 0,  1, 16'h0006, 0, 16'h2003, 16'h0006, 0);
        vecs[14] = mk(1, 16'hDEAD, 0, 16'h0000, 0,  1, 16'h0006, 0, 16'h2003, 16'h0006, 0);
        vecs[15] = mk(1, 16'h2004, 0, 16'h0000, 0,  1, 16'h0100, 0, 16'h2003, 16'h0006, 0);
        vecs[16] = mk(0, 16'h0000, 1, 16'h0011, 0,  0, 16'h0100, 1, 16'h2004, 16'h0102, 0);
        vecs[17] = mk(1, 16'h2005, 0, 16'h0000, 0,  1, 16'h0010, 0, 16'h2004, 16'h0102, 0);
        vecs[18] = mk(0, 16'h0000, 1, 16'h0041, 1,  0, 16'h0010, 1, 16'h2005, 16'h0012, 0);
        vecs[19] = mk(1, 16'h2006, 0, 16'h0000, 0,  1, 16'h0040, 0, 16'h2005, 16'h0012, 0);
        vecs[20] = mk(0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0040, 1, 16'h2006, 16'h0042, 0);
        vecs[21] = mk(1, 16'hBEEF, 1, 16'h0080, 0,  1, 16'h0042, 0, 16'h2006, 16'h0042, 0);
        vecs[22] = mk(1, 16'h2007, 0, 16'h0000, 0,  1, 16'h0080, 0, 16'h2006, 16'h0042, 0);
        vecs[23] = mk(0, 16'h0000, 1, 16'h0006, 0,  0, 16'h0080, 1, 16'h2007, 16'h0082, 0);
        vecs[24] = mk(1, 16'h0000, 0, 16'h0000, 0,  1, 16'h0006, 0, 16'h2007, 16'h0082, 0);
        vecs[25] = mk(0, 16'h0000, 0, 16'h0000, 1,  0, 16'h0006, 1, 16'h0000, 16'h0008, 0);
        vecs[26] = mk(0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0006, 1, 16'h0000, 16'h0008, 0);
        vecs[27] = mk(1, 16'h1111, 1, 16'h0200, 0,  0, 16'h0006, 0, 16'h0000, 16'h0008, 1);
        vecs[28] = mk(1, 16'h2222, 1, 16'h0300, 1,  0, 16'h0006, 0, 16'h0000, 16'h0008, 1);

        rst = 1'b1;
        rst_w = 1'b1;
        imem_done = 1'b0;
        imem_rdata = 16'h0000;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        stall = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk_all("reset", 1'b0, 16'h0000, 1'b0, 16'h0800, 16'h0000, 1'b0);

        // Main table: inputs applied and outputs sampled mid low phase.
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NVEC; k++) begin
            if (k != 0) @(negedge clk);
            imem_done   = vecs[k].done;
            imem_rdata  = vecs[k].rdata;
            redirect    = vecs[k].redir;
            redirect_pc = vecs[k].rpc;
            stall       = vecs[k].stl;
            #1;
            chk_all($sformatf("vec%0d", k), vecs[k].req, vecs[k].addr, vecs[k].valid,
                    vecs[k].instr, vecs[k].pcp2, vecs[k].halt);
        end
        @(negedge clk);
        redirect = 1'b0;
        stall = 1'b0;
        imem_done = 1'b0;
        #1;
        chk_all("halt_hold", 1'b0, 16'h0006, 1'b0, 16'h0000, 16'h0008, 1'b1);

        // Asynchronous reset out of HALTED, then restart at RESET_PC.
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst_halted", 1'b0, 16'h0000, 1'b0, 16'h0800, 16'h0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all("restart_start", 1'b0, 16'h0000, 1'b0, 16'h0800, 16'h0000, 1'b0);
        @(negedge clk);
        #1;
        chk_all("restart_fetch", 1'b1, 16'h0000, 1'b0, 16'h0800, 16'h0000, 1'b0);

        // Reset in the middle of a completing fetch: the response must be ignored.
        imem_done = 1'b1;
        imem_rdata = 16'h1234;
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst_fetch", 1'b0, 16'h0000, 1'b0, 16'h0800, 16'h0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all("post_rst_start", 1'b0, 16'h0000, 1'b0, 16'h0800, 16'h0000, 1'b0);
        imem_done = 1'b0;
        @(negedge clk);
        #1;
        chk_all("post_rst_fetch", 1'b1, 16'h0000, 1'b0, 16'h0800, 16'h0000, 1'b0);

        // PC wrap on the second instance (RESET_PC = 16'hFFFE, zero-wait memory).
        #1;
        chk("wrap reset addr", imem_addr_w, 16'hFFFE);
        chk("wrap reset req",  {15'd0, imem_req_w}, 16'h0000);
        @(negedge clk);
        rst_w = 1'b0;
        #1;
        chk("wrap start req", {15'd0, imem_req_w}, 16'h0000);
        @(negedge clk);
        #1;
        chk("wrap fetch1 req",  {15'd0, imem_req_w}, 16'h0001);
        chk("wrap fetch1 addr", imem_addr_w, 16'hFFFE);
        @(negedge clk);
        #1;
        chk("wrap issue valid", {15'd0, inst_valid_w}, 16'h0001);
        chk("wrap issue instr", instruction_w, 16'h2001);
        chk("wrap issue pcp2",  pc_plus2_w, 16'h0000);
        chk("wrap issue halted", {15'd0, halted_w}, 16'h0000);
        @(negedge clk);
        #1;
        chk("wrap fetch2 req",  {15'd0, imem_req_w}, 16'h0001);
        chk("wrap fetch2 addr", imem_addr_w, 16'h0000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
